// File: rtl/sw_pkg.sv
// Shared types and constants for the SW_core job dispatcher.
package sw_pkg;

    localparam int unsigned DP_SW_SCORE_BITWIDTH = 16;

    // Result status codes returned to the host
    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BAD_LEN = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        StHdr,
        StLdRef,
        StLdRead,
        StIssue,
        StWaitRes,
        StResp
    } sw_disp_state_e;

    // Host words needed to fill the ref vector (2 bits per base)
    function automatic int unsigned ref_words(input int unsigned ref_max_length,
                                              input int unsigned word_w);
        return (2 * ref_max_length) / word_w;
    endfunction

    // Host words needed to fill the read vector (2 bits per base)
    function automatic int unsigned read_words(input int unsigned read_max_length,
                                               input int unsigned word_w);
        return (2 * read_max_length) / word_w;
    endfunction

endpackage

// File: rtl/sw_job_dispatcher_if.sv
// Host word stream, SW_core job/result handshakes and host result port.
// slave: the dispatcher's view; master: the host/core environment's view.
interface sw_job_dispatcher_if
    import sw_pkg::*;
#(
    parameter int unsigned REF_MAX_LENGTH  = 128,
    parameter int unsigned READ_MAX_LENGTH = 128,
    parameter int unsigned SCORE_W         = DP_SW_SCORE_BITWIDTH,
    parameter int unsigned WORD_W          = 32
);
    localparam int unsigned RefLenW  = $clog2(REF_MAX_LENGTH) + 1;
    localparam int unsigned ReadLenW = $clog2(READ_MAX_LENGTH) + 1;
    localparam int unsigned ColW     = $clog2(REF_MAX_LENGTH);
    localparam int unsigned RowW     = $clog2(READ_MAX_LENGTH);

    logic                         i_word_valid;
    logic                         o_word_ready;
    logic [WORD_W-1:0]            i_word_data;
    logic                         o_sw_valid;
    logic                         i_sw_ready;
    logic [2*REF_MAX_LENGTH-1:0]  o_sequence_ref;
    logic [2*READ_MAX_LENGTH-1:0] o_sequence_read;
    logic [RefLenW-1:0]           o_seq_ref_length;
    logic [ReadLenW-1:0]          o_seq_read_length;
    logic                         o_sw_ready;
    logic                         i_sw_valid;
    logic [SCORE_W-1:0]           i_sw_score;
    logic [ColW-1:0]              i_sw_column;
    logic [RowW-1:0]              i_sw_row;
    logic                         o_res_valid;
    logic                         i_res_ready;
    logic [SCORE_W-1:0]           o_res_score;
    logic [ColW-1:0]              o_res_column;
    logic [RowW-1:0]              o_res_row;
    logic [7:0]                   o_res_id;
    logic [1:0]                   o_res_status;

    modport slave (
        input  i_word_valid, i_word_data, i_sw_ready, i_sw_valid, i_sw_score, i_sw_column,
               i_sw_row, i_res_ready,
        output o_word_ready, o_sw_valid, o_sequence_ref, o_sequence_read, o_seq_ref_length,
               o_seq_read_length, o_sw_ready, o_res_valid, o_res_score, o_res_column,
               o_res_row, o_res_id, o_res_status
    );

    modport master (
        output i_word_valid, i_word_data, i_sw_ready, i_sw_valid, i_sw_score, i_sw_column,
               i_sw_row, i_res_ready,
        input  o_word_ready, o_sw_valid, o_sequence_ref, o_sequence_read, o_seq_ref_length,
               o_seq_read_length, o_sw_ready, o_res_valid, o_res_score, o_res_column,
               o_res_row, o_res_id, o_res_status
    );

endinterface

// File: rtl/sw_seq_packer.sv
// Shift-in word assembler: first word ends up in the MSBs, each later word
// enters from the right. o_last flags that the next loaded word completes
// the vector; the counter then wraps so the next job starts aligned.
module sw_seq_packer #(
    parameter int unsigned VEC_W  = 256,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    output logic [VEC_W-1:0]  o_vec,
    output logic              o_last
);
    localparam int unsigned Words = VEC_W / WORD_W;
    localparam int unsigned CntW  = (Words > 1) ? $clog2(Words) : 1;

    logic [CntW-1:0]  r_cnt;
    logic [VEC_W-1:0] r_vec;
    logic             w_last;

    assign w_last = (r_cnt == CntW'(Words - 1));

    // Shift in accepted words and track the word slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_vec <= '0;
        end else if (i_load) begin
            r_vec <= {r_vec[VEC_W-WORD_W-1:0], i_word};
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_vec  = r_vec;
    assign o_last = w_last;

endmodule

// File: rtl/sw_job_dispatcher.sv
// Host-side initiator for SW_core: loads one job from the host word stream,
// issues it to the core, captures the result (or a watchdog timeout) and
// returns it tagged with a wrapping job ID. All outputs are registered.
module sw_job_dispatcher
    import sw_pkg::*;
#(
    parameter int unsigned REF_MAX_LENGTH  = 128,
    parameter int unsigned READ_MAX_LENGTH = 128,
    parameter int unsigned SCORE_W         = DP_SW_SCORE_BITWIDTH,
    parameter int unsigned WORD_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
    input logic                clk,
    input logic                rst,
    sw_job_dispatcher_if.slave bus
);
    localparam int unsigned RefVecW  = 2 * REF_MAX_LENGTH;
    localparam int unsigned ReadVecW = 2 * READ_MAX_LENGTH;
    localparam int unsigned RefLenW  = $clog2(REF_MAX_LENGTH) + 1;
    localparam int unsigned ReadLenW = $clog2(READ_MAX_LENGTH) + 1;
    localparam int unsigned ColW     = $clog2(REF_MAX_LENGTH);
    localparam int unsigned RowW     = $clog2(READ_MAX_LENGTH);
    localparam int unsigned HalfW    = WORD_W / 2;
    localparam int unsigned WdogW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HalfW-1:0] RefMaxHdr  = HalfW'(REF_MAX_LENGTH);
    localparam logic [HalfW-1:0] ReadMaxHdr = HalfW'(READ_MAX_LENGTH);

    sw_disp_state_e      r_state, w_state_d;
    logic                r_word_ready, w_word_ready_d;
    logic                r_sw_valid, w_sw_valid_d;
    logic                r_sw_ready, w_sw_ready_d;
    logic                r_res_valid, w_res_valid_d;
    logic [1:0]          r_status, w_status_d;
    logic [7:0]          r_id, w_id_d;
    logic [SCORE_W-1:0]  r_res_score, w_res_score_d;
    logic [ColW-1:0]     r_res_column, w_res_column_d;
    logic [RowW-1:0]     r_res_row, w_res_row_d;
    logic [RefLenW-1:0]  r_ref_len, w_ref_len_d;
    logic [ReadLenW-1:0] r_read_len, w_read_len_d;
    logic [WdogW-1:0]    r_wdog, w_wdog_d;

    logic                w_word_fire, w_res_fire;
    logic [HalfW-1:0]    w_hdr_ref, w_hdr_read;
    logic                w_len_ok;
    logic                w_ref_load, w_read_load, w_ref_last, w_read_last;
    logic [RefVecW-1:0]  w_ref_vec;
    logic [ReadVecW-1:0] w_read_vec;

    assign w_word_fire = r_word_ready & bus.i_word_valid;
    assign w_res_fire  = r_res_valid & bus.i_res_ready;
    assign w_hdr_ref   = bus.i_word_data[WORD_W-1:HalfW];
    assign w_hdr_read  = bus.i_word_data[HalfW-1:0];
    assign w_len_ok    = (w_hdr_ref != '0) && (w_hdr_ref <= RefMaxHdr) &&
                         (w_hdr_read != '0) && (w_hdr_read <= ReadMaxHdr);
    assign w_ref_load  = w_word_fire && (r_state == StLdRef);
    assign w_read_load = w_word_fire && (r_state == StLdRead);

    sw_seq_packer #(
        .VEC_W  (RefVecW),
        .WORD_W (WORD_W)
    ) u_ref_packer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_ref_load),
        .i_word (bus.i_word_data),
        .o_vec  (w_ref_vec),
        .o_last (w_ref_last)
    );

    sw_seq_packer #(
        .VEC_W  (ReadVecW),
        .WORD_W (WORD_W)
    ) u_read_packer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_read_load),
        .i_word (bus.i_word_data),
        .o_vec  (w_read_vec),
        .o_last (w_read_last)
    );

    // Next-state and next-output logic for the job FSM, watchdog and result
    always_comb begin
        w_state_d      = r_state;
        w_word_ready_d = r_word_ready;
        w_sw_valid_d   = r_sw_valid;
        w_sw_ready_d   = r_sw_ready;
        w_res_valid_d  = r_res_valid;
        w_status_d     = r_status;
        w_id_d         = r_id;
        w_res_score_d  = r_res_score;
        w_res_column_d = r_res_column;
        w_res_row_d    = r_res_row;
        w_ref_len_d    = r_ref_len;
        w_read_len_d   = r_read_len;
        w_wdog_d       = r_wdog;
        unique case (r_state)
            StHdr: begin
                w_word_ready_d = 1'b1;
                if (w_word_fire) begin
                    w_ref_len_d  = w_hdr_ref[RefLenW-1:0];
                    w_read_len_d = w_hdr_read[ReadLenW-1:0];
                    // A bad job still drains its sequence words to stay framed
                    if (!w_len_ok) w_status_d = ST_BAD_LEN;
                    w_state_d = StLdRef;
                end
            end
            StLdRef: begin
                if (w_ref_load && w_ref_last) w_state_d = StLdRead;
            end
            StLdRead: begin
                if (w_read_load && w_read_last) begin
                    w_word_ready_d = 1'b0;
                    if (r_status == ST_BAD_LEN) begin
                        w_res_score_d  = '0;
                        w_res_column_d = '0;
                        w_res_row_d    = '0;
                        w_res_valid_d  = 1'b1;
                        w_state_d      = StResp;
                    end else begin
                        w_state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (r_sw_valid) begin
                    w_sw_valid_d = 1'b0;
                    w_sw_ready_d = 1'b1;
                    w_wdog_d     = '0;
                    w_state_d    = StWaitRes;
                end else if (bus.i_sw_ready) begin
                    w_sw_valid_d = 1'b1;
                end
            end
            StWaitRes: begin
                // Valid data takes priority over a coincident timeout
                if (bus.i_sw_valid) begin
                    w_res_score_d  = bus.i_sw_score;
                    w_res_column_d = bus.i_sw_column;
                    w_res_row_d    = bus.i_sw_row;
                    w_status_d     = ST_OK;
                    w_sw_ready_d   = 1'b0;
                    w_res_valid_d  = 1'b1;
                    w_state_d      = StResp;
                end else if (r_wdog == WdogW'(TIMEOUT_CYCLES - 1)) begin
                    w_res_score_d  = '0;
                    w_res_column_d = '0;
                    w_res_row_d    = '0;
                    w_status_d     = ST_TIMEOUT;
                    w_sw_ready_d   = 1'b0;
                    w_res_valid_d  = 1'b1;
                    w_state_d      = StResp;
                end else begin
                    w_wdog_d = r_wdog + 1'b1;
                end
            end
            StResp: begin
                if (w_res_fire) begin
                    w_res_valid_d  = 1'b0;
                    w_id_d         = r_id + 8'd1;
                    w_status_d     = ST_OK;
                    w_word_ready_d = 1'b1;
                    w_state_d      = StHdr;
                end
            end
            default: w_state_d = StHdr;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StHdr;
            r_word_ready <= 1'b0;
            r_sw_valid   <= 1'b0;
            r_sw_ready   <= 1'b0;
            r_res_valid  <= 1'b0;
            r_status     <= ST_OK;
            r_id         <= '0;
            r_res_score  <= '0;
            r_res_column <= '0;
            r_res_row    <= '0;
            r_ref_len    <= '0;
            r_read_len   <= '0;
            r_wdog       <= '0;
        end else begin
            r_state      <= w_state_d;
            r_word_ready <= w_word_ready_d;
            r_sw_valid   <= w_sw_valid_d;
            r_sw_ready   <= w_sw_ready_d;
            r_res_valid  <= w_res_valid_d;
            r_status     <= w_status_d;
            r_id         <= w_id_d;
            r_res_score  <= w_res_score_d;
            r_res_column <= w_res_column_d;
            r_res_row    <= w_res_row_d;
            r_ref_len    <= w_ref_len_d;
            r_read_len   <= w_read_len_d;
            r_wdog       <= w_wdog_d;
        end
    end

    // Job vectors and lengths are only presented during the issue pulse
    assign bus.o_sequence_ref    = r_sw_valid ? w_ref_vec  : '0;
    assign bus.o_sequence_read   = r_sw_valid ? w_read_vec : '0;
    assign bus.o_seq_ref_length  = r_sw_valid ? r_ref_len  : '0;
    assign bus.o_seq_read_length = r_sw_valid ? r_read_len : '0;
    assign bus.o_word_ready      = r_word_ready;
    assign bus.o_sw_valid        = r_sw_valid;
    assign bus.o_sw_ready        = r_sw_ready;
    assign bus.o_res_valid       = r_res_valid;
    assign bus.o_res_score       = r_res_score;
    assign bus.o_res_column      = r_res_column;
    assign bus.o_res_row         = r_res_row;
    assign bus.o_res_id          = r_id;
    assign bus.o_res_status      = r_status;

endmodule
